// File: rtl/max7219_scheduler.sv
// ---------------------------------------------------------------------------
// max7219_scheduler
//
// Word-level controller for a MAX7219 display driver. After reset it sends
// the five-word power-up sequence. From then on it sends only what has
// changed:
//   - digits written into the eight-entry display buffer
//   - shutdown, decode and intensity settings that differ from what was sent
// It can also force a periodic resend of everything.
// Words go out one at a time to a 16-bit SPI shifter. A word is offered with
// a valid/ready handshake. The shifter then pulses done once the word has
// been shifted out.
//
// Parameters
//   SCAN_LIMIT      data written to the scan-limit register during init
//   REFRESH_CYCLES  clk cycles between forced full refreshes, 0 disables
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   wr_en        in   display buffer write strobe
//   wr_digit     in   digit index 0..7 for the write
//   wr_data      in   digit code, bit 7 is the decimal point
//   intensity    in   brightness level (register 0x0A)
//   decode_mask  in   BCD decode mask (register 0x09)
//   blank        in   1 = shutdown mode, 0 = normal operation
//   word_valid   out  word offered to the serializer
//   word_addr    out  MAX7219 register address
//   word_data    out  register data
//   word_ready   in   serializer accepts the word while word_valid is high
//   word_done    in   pulse: accepted word fully shifted out
//   init_done    out  power-up sequence finished
//   busy         out  a word is offered or still being shifted
// ---------------------------------------------------------------------------
module max7219_scheduler #(
   parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
   parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_digit,
   input  logic [7:0] wr_data,
   input  logic [3:0] intensity,
   input  logic [7:0] decode_mask,
   input  logic       blank,
   output logic       word_valid,
   output logic [7:0] word_addr,
   output logic [7:0] word_data,
   input  logic       word_ready,
   input  logic       word_done,
   output logic       init_done,
   output logic       busy
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT} state_t;
   typedef enum logic [1:0] {SEL_DIGIT, SEL_SHUTDOWN, SEL_DECODE, SEL_INTENSITY} sel_t;

   localparam logic [31:0] REFRESH_LAST =
      (REFRESH_CYCLES == 0) ? 32'd0 : 32'(REFRESH_CYCLES - 1);

   state_t      state;
   sel_t        sel_kind;
   logic [2:0]  sel_digit;
   logic [2:0]  init_step;
   logic [7:0]  digit_buf [8];
   logic [7:0]  digit_dirty, dirty_next;
   logic        dirty_shutdown, dirty_decode, dirty_intensity;
   logic        shutdown_next, decode_next, intensity_next;
   logic [3:0]  intensity_q;
   logic [7:0]  decode_q;
   logic        blank_q;
   logic [31:0] refresh_cnt;

   logic        accept, init_finish, refresh_hit;
   logic [7:0]  shutdown_data, decode_data, intensity_data;
   logic [7:0]  init_addr, init_data, sel_addr, sel_data;
   logic [2:0]  first_dirty;

   assign busy           = word_valid | (state == S_WAIT);
   assign accept         = word_valid && word_ready && (state == S_ISSUE);
   assign init_finish    = (state == S_WAIT) && word_done && !init_done && (init_step == 3'd4);
   assign refresh_hit    = (REFRESH_CYCLES != 0) && init_done && (refresh_cnt == REFRESH_LAST);
   assign shutdown_data  = {7'h0, ~blank};
   assign decode_data    = decode_mask;
   assign intensity_data = {4'h0, intensity};

   // Power-up sequence: display test off, scan limit, decode, intensity, shutdown.
   always_comb begin
      init_addr = 8'h0F;
      init_data = 8'h00;
      case (init_step)
         3'd1:    begin init_addr = 8'h0B; init_data = {5'h0, SCAN_LIMIT}; end
         3'd2:    begin init_addr = 8'h09; init_data = decode_data;        end
         3'd3:    begin init_addr = 8'h0A; init_data = intensity_data;     end
         3'd4:    begin init_addr = 8'h0C; init_data = shutdown_data;      end
         default: begin init_addr = 8'h0F; init_data = 8'h00;              end
      endcase
   end

   // Lowest-index dirty digit, and the word for whatever IDLE selected.
   // Data is read live, so the word carries the value at load time.
   always_comb begin
      first_dirty = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (digit_dirty[i]) first_dirty = 3'(i);
      case (sel_kind)
         SEL_SHUTDOWN:  begin sel_addr = 8'h0C; sel_data = shutdown_data;  end
         SEL_DECODE:    begin sel_addr = 8'h09; sel_data = decode_data;    end
         SEL_INTENSITY: begin sel_addr = 8'h0A; sel_data = intensity_data; end
         default:       begin sel_addr = {5'h0, sel_digit} + 8'd1; sel_data = digit_buf[sel_digit]; end
      endcase
   end

   // A flag is only cleared on acceptance if the accepted data is still the
   // current value; anything that changed while the word was held stays pending.
   // New writes, config changes and refresh set flags after the clear, so they win.
   always_comb begin
      dirty_next      = digit_dirty;
      shutdown_next   = dirty_shutdown;
      decode_next     = dirty_decode;
      intensity_next  = dirty_intensity;
      if (accept && sel_kind == SEL_DIGIT && word_data == digit_buf[sel_digit])
         dirty_next[sel_digit] = 1'b0;
      if (accept && sel_kind == SEL_SHUTDOWN && word_data == shutdown_data)
         shutdown_next = 1'b0;
      if (accept && sel_kind == SEL_DECODE && word_data == decode_data)
         decode_next = 1'b0;
      if (accept && sel_kind == SEL_INTENSITY && word_data == intensity_data)
         intensity_next = 1'b0;
      if (wr_en)
         dirty_next[wr_digit] = 1'b1;
      if (init_done && blank != blank_q)
         shutdown_next = 1'b1;
      if (init_done && decode_mask != decode_q)
         decode_next = 1'b1;
      if (init_done && intensity != intensity_q)
         intensity_next = 1'b1;
      if (refresh_hit) begin
         dirty_next     = 8'hFF;
         shutdown_next  = 1'b1;
         decode_next    = 1'b1;
         intensity_next = 1'b1;
      end
      if (init_finish) begin
         shutdown_next  = 1'b0;
         decode_next    = 1'b0;
         intensity_next = 1'b0;
      end
   end

   // Display buffer, dirty flags and config shadow copies.
   // The copies track the inputs during init too, so finishing init raises no false change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) digit_buf[i] <= 8'h00;
         digit_dirty     <= 8'hFF;
         dirty_shutdown  <= 1'b0;
         dirty_decode    <= 1'b0;
         dirty_intensity <= 1'b0;
         intensity_q     <= 4'h0;
         decode_q        <= 8'h00;
         blank_q         <= 1'b0;
      end else begin
         if (wr_en) digit_buf[wr_digit] <= wr_data;
         digit_dirty     <= dirty_next;
         dirty_shutdown  <= shutdown_next;
         dirty_decode    <= decode_next;
         dirty_intensity <= intensity_next;
         intensity_q     <= intensity;
         decode_q        <= decode_mask;
         blank_q         <= blank;
      end
   end

   // Free-running refresh timer, started once init is complete.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         refresh_cnt <= 32'd0;
      else if (REFRESH_CYCLES != 0 && init_done)
         refresh_cnt <= refresh_hit ? 32'd0 : refresh_cnt + 32'd1;
   end

   // Handshake sequencer. S_INIT and S_ISSUE both load the word in their first cycle.
   // They then hold it until it is accepted. S_WAIT waits for the shifter to finish.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_INIT;
         init_step  <= 3'd0;
         sel_kind   <= SEL_DIGIT;
         sel_digit  <= 3'd0;
         word_valid <= 1'b0;
         word_addr  <= 8'h00;
         word_data  <= 8'h00;
         init_done  <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               if (!word_valid) begin
                  word_addr  <= init_addr;
                  word_data  <= init_data;
                  word_valid <= 1'b1;
               end else if (word_ready) begin
                  word_valid <= 1'b0;
                  state      <= S_WAIT;
               end
            end
            S_IDLE: begin
               if (dirty_shutdown) begin
                  sel_kind <= SEL_SHUTDOWN;
                  state    <= S_ISSUE;
               end else if (dirty_decode) begin
                  sel_kind <= SEL_DECODE;
                  state    <= S_ISSUE;
               end else if (dirty_intensity) begin
                  sel_kind <= SEL_INTENSITY;
                  state    <= S_ISSUE;
               end else if (|digit_dirty) begin
                  sel_kind  <= SEL_DIGIT;
                  sel_digit <= first_dirty;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!word_valid) begin
                  word_addr  <= sel_addr;
                  word_data  <= sel_data;
                  word_valid <= 1'b1;
               end else if (word_ready) begin
                  word_valid <= 1'b0;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (word_done) begin
                  if (init_done) begin
                     state <= S_IDLE;
                  end else if (init_step == 3'd4) begin
                     init_done <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     init_step <= init_step + 3'd1;
                     state     <= S_INIT;
                  end
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_max7219_scheduler.sv
// ---------------------------------------------------------------------------
// tb_max7219_scheduler
//
// Testbench for max7219_scheduler. It drives two instances:
//   - the main DUT, with refresh disabled, driven by a directed and
//     randomized sequence
//   - a second DUT with REFRESH_CYCLES=200, left running on its own
// A behavioural model tracks the display buffer, pending digits and pending
// config registers, and lists the words that should come out, in order.
// Simple serializer models answer the handshake for each DUT.
// ---------------------------------------------------------------------------
module tb_max7219_scheduler;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_digit;
   logic [7:0] wr_data;
   logic [3:0] intensity;
   logic [7:0] decode_mask;
   logic       blank;
   logic       word_valid;
   logic [7:0] word_addr;
   logic [7:0] word_data;
   logic       word_ready;
   logic       word_done;
   logic       init_done;
   logic       busy;

   logic       reset_r;
   logic       wr_en_r;
   logic [2:0] wr_digit_r;
   logic [7:0] wr_data_r;
   logic [3:0] intensity_r;
   logic [7:0] decode_mask_r;
   logic       blank_r;
   logic       word_valid_r;
   logic [7:0] word_addr_r;
   logic [7:0] word_data_r;
   logic       word_ready_r;
   logic       word_done_r;
   logic       init_done_r;
   logic       busy_r;

   int compare_count = 0;
   int fail_count    = 0;
   int done_delay    = 20;
   int rst_epoch     = 0;
   int cycle_count   = 0;

   logic [7:0] obs_addr[$];
   logic [7:0] obs_data[$];
   logic [7:0] exp_addr[$];
   logic [7:0] exp_data[$];
   logic [7:0] obs2_addr[$];
   logic [7:0] obs2_data[$];
   int         obs2_time[$];
   logic [7:0] e2_addr[$];
   logic [7:0] e2_data[$];

   logic [7:0] m_buf [8];
   logic [7:0] m_dirty;
   bit         m_shut, m_dec, m_int;

   max7219_scheduler #(.SCAN_LIMIT(3'd7), .REFRESH_CYCLES(0)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_digit(wr_digit), .wr_data(wr_data),
      .intensity(intensity), .decode_mask(decode_mask), .blank(blank),
      .word_valid(word_valid), .word_addr(word_addr), .word_data(word_data),
      .word_ready(word_ready), .word_done(word_done), .init_done(init_done), .busy(busy)
   );

   max7219_scheduler #(.SCAN_LIMIT(3'd4), .REFRESH_CYCLES(200)) dut_refresh (
      .clk(clk), .reset(reset_r), .wr_en(wr_en_r), .wr_digit(wr_digit_r), .wr_data(wr_data_r),
      .intensity(intensity_r), .decode_mask(decode_mask_r), .blank(blank_r),
      .word_valid(word_valid_r), .word_addr(word_addr_r), .word_data(word_data_r),
      .word_ready(word_ready_r), .word_done(word_done_r), .init_done(init_done_r), .busy(busy_r)
   );

   // Clock and cycle counter used to time the refresh period.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle_count <= cycle_count + 1;

   // Reset epochs let the serializer abandon a word that a reset aborted.
   always @(negedge reset) rst_epoch <= rst_epoch + 1;

   // Serializer model for the main DUT: it logs each accepted word, then
   // pulses done after done_delay cycles.
   initial begin
      int ep;
      word_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset && word_valid && word_ready) begin
            ep = rst_epoch;
            obs_addr.push_back(word_addr);
            obs_data.push_back(word_data);
            repeat (done_delay) @(negedge clk);
            if (ep == rst_epoch) begin
               word_done = 1'b1;
               @(negedge clk);
               word_done = 1'b0;
            end
         end
      end
   end

   // Serializer model for the refresh DUT: always ready, done after four cycles.
   initial begin
      word_done_r = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_r && word_valid_r && word_ready_r) begin
            obs2_addr.push_back(word_addr_r);
            obs2_data.push_back(word_data_r);
            obs2_time.push_back(cycle_count);
            repeat (4) @(negedge clk);
            word_done_r = 1'b1;
            @(negedge clk);
            word_done_r = 1'b0;
         end
      end
   end

   // Last-resort guard so the run always ends.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_buf[i] = 8'h00;
      m_dirty = 8'hFF;
      m_shut  = 1'b0;
      m_dec   = 1'b0;
      m_int   = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
      exp_addr.push_back(a);
      exp_data.push_back(d);
   endtask

   task automatic expect_init(input logic [7:0] scan);
      push_exp(8'h0F, 8'h00);
      push_exp(8'h0B, scan);
      push_exp(8'h09, decode_mask);
      push_exp(8'h0A, {4'h0, intensity});
      push_exp(8'h0C, {7'h0, ~blank});
   endtask

   // Everything pending is sent: config by fixed priority, then digits in ascending order.
   task automatic expect_pending();
      if (m_shut) push_exp(8'h0C, {7'h0, ~blank});
      if (m_dec)  push_exp(8'h09, decode_mask);
      if (m_int)  push_exp(8'h0A, {4'h0, intensity});
      for (int i = 0; i < 8; i++)
         if (m_dirty[i]) push_exp(8'(i + 1), m_buf[i]);
      m_shut  = 1'b0;
      m_dec   = 1'b0;
      m_int   = 1'b0;
      m_dirty = 8'h00;
   endtask

   task automatic write_digit(input logic [2:0] d, input logic [7:0] v);
      wr_en    = 1'b1;
      wr_digit = d;
      wr_data  = v;
      m_buf[d] = v;
      m_dirty[d] = 1'b1;
      step();
      wr_en = 1'b0;
   endtask

   // Digit write that the bench expects to go out on its own as the next word.
   task automatic kick(input logic [2:0] d, input logic [7:0] v);
      write_digit(d, v);
      push_exp(8'({5'h0, d} + 8'd1), v);
      m_dirty[d] = 1'b0;
   endtask

   task automatic set_intensity(input logic [3:0] v);
      if (v != intensity) m_int = 1'b1;
      intensity = v;
      step();
   endtask

   task automatic set_decode(input logic [7:0] v);
      if (v != decode_mask) m_dec = 1'b1;
      decode_mask = v;
      step();
   endtask

   task automatic set_blank(input logic b);
      if (b != blank) m_shut = 1'b1;
      blank = b;
      step();
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (word_valid !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check_output({tag, "_valid"}, 32'(word_valid), 32'd1);
   endtask

   task automatic wait_accepts(input string tag, input int count, input int budget);
      int n;
      n = 0;
      while (obs_addr.size() < count && n < budget) begin
         step();
         n++;
      end
      check_output({tag, "_accepted"}, 32'(obs_addr.size() >= count), 32'd1);
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int quiet, n;
      quiet = 0;
      n = 0;
      while (quiet < 8 && n < budget) begin
         step();
         n++;
         if (busy === 1'b0) quiet++;
         else quiet = 0;
      end
      check_output({tag, "_quiet"}, 32'(quiet >= 8), 32'd1);
   endtask

   task automatic compare_words(input string tag);
      wait_quiet(tag, 4000);
      check_output({tag, "_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (i < obs_addr.size()) begin
            check_output($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
            check_output($sformatf("%s_data%0d", tag, i), 32'(obs_data[i]), 32'(exp_data[i]));
         end
      end
      obs_addr.delete();
      obs_data.delete();
      exp_addr.delete();
      exp_data.delete();
   endtask

   // Directed and randomized sequence.
   initial begin
      logic [2:0] k, j;
      logic [7:0] v, w;
      int         nw;

      reset         = 1'b0;
      wr_en         = 1'b0;
      wr_digit      = 3'd0;
      wr_data       = 8'h00;
      intensity     = 4'd3;
      decode_mask   = 8'($urandom);
      blank         = 1'b0;
      word_ready    = 1'b1;
      reset_r       = 1'b0;
      wr_en_r       = 1'b0;
      wr_digit_r    = 3'd0;
      wr_data_r     = 8'h00;
      intensity_r   = 4'd5;
      decode_mask_r = 8'hFF;
      blank_r       = 1'b0;
      word_ready_r  = 1'b1;

      // Outputs while held in reset.
      repeat (3) step();
      check_output("rst_valid", 32'(word_valid), 32'd0);
      check_output("rst_addr",  32'(word_addr),  32'd0);
      check_output("rst_data",  32'(word_data),  32'd0);
      check_output("rst_init",  32'(init_done),  32'd0);
      check_output("rst_busy",  32'(busy),       32'd0);

      // Init sequence, then all eight digits (dirty from reset).
      reset   = 1'b1;
      reset_r = 1'b1;
      model_reset();
      expect_init(8'h07);
      expect_pending();
      compare_words("init");
      check_output("post_init_done", 32'(init_done), 32'd1);
      check_output("post_init_busy", 32'(busy), 32'd0);

      // A single write while idle.
      write_digit(3'd3, 8'h85);
      expect_pending();
      compare_words("single");

      // Two writes to one digit inside a gap: only the last value goes out.
      kick(3'($urandom_range(0, 7)), 8'($urandom));
      wait_accepts("coalesce", 1, 200);
      write_digit(3'd3, 8'h11);
      write_digit(3'd3, 8'h22);
      expect_pending();
      compare_words("coalesce");

      // Word held by ready=0: it must stay stable. An intensity change made
      // meanwhile goes out before the digit written meanwhile.
      word_ready = 1'b0;
      k = 3'($urandom_range(0, 7));
      v = 8'($urandom);
      j = k + 3'($urandom_range(1, 7));
      w = 8'($urandom);
      kick(k, v);
      wait_valid("hold", 50);
      for (int c = 0; c < 10; c++) begin
         check_output("hold_addr", 32'(word_addr), 32'({5'h0, k} + 8'd1));
         check_output("hold_data", 32'(word_data), 32'(v));
         if (c == 3) set_intensity(4'd9);
         else if (c == 6) write_digit(j, w);
         else step();
      end
      word_ready = 1'b1;
      expect_pending();
      compare_words("hold");

      // A write to the digit in the same cycle it is accepted: the digit is
      // sent again with the new data.
      word_ready = 1'b0;
      k = 3'($urandom_range(0, 7));
      v = 8'($urandom);
      kick(k, v);
      wait_valid("accwr", 50);
      word_ready = 1'b1;
      wr_en      = 1'b1;
      wr_digit   = k;
      wr_data    = v ^ 8'h5A;
      m_buf[k]   = v ^ 8'h5A;
      m_dirty[k] = 1'b1;
      step();
      wr_en = 1'b0;
      expect_pending();
      compare_words("accwr");

      // All three config registers plus two digits change during one gap.
      kick(3'($urandom_range(0, 7)), 8'($urandom));
      wait_accepts("cfgall", 1, 200);
      write_digit(3'd6, 8'($urandom));
      set_blank(~blank);
      set_intensity(intensity + 4'd1);
      set_decode(~decode_mask);
      write_digit(3'd1, 8'($urandom));
      expect_pending();
      compare_words("cfgall");

      // Randomized batches: random writes and config changes during a gap.
      for (int b = 0; b < 6; b++) begin
         kick(3'($urandom_range(0, 7)), 8'($urandom));
         wait_accepts("rand", 1, 200);
         nw = $urandom_range(1, 5);
         for (int i = 0; i < nw; i++) write_digit(3'($urandom_range(0, 7)), 8'($urandom));
         if ($urandom_range(0, 1) == 1) set_intensity(4'($urandom));
         if ($urandom_range(0, 1) == 1) set_decode(8'($urandom));
         if ($urandom_range(0, 1) == 1) set_blank(~blank);
         expect_pending();
         compare_words($sformatf("rand%0d", b));
      end

      // A reset in the middle of a word clears the outputs at once and restarts init.
      word_ready = 1'b1;
      kick(3'($urandom_range(0, 7)), 8'($urandom));
      exp_addr.delete();
      exp_data.delete();
      wait_valid("midrst", 50);
      reset = 1'b0;
      #1;
      check_output("midrst_valid", 32'(word_valid), 32'd0);
      check_output("midrst_addr",  32'(word_addr),  32'd0);
      check_output("midrst_data",  32'(word_data),  32'd0);
      check_output("midrst_init",  32'(init_done),  32'd0);
      check_output("midrst_busy",  32'(busy),       32'd0);
      step();
      step();
      reset = 1'b1;
      model_reset();
      expect_init(8'h07);
      expect_pending();
      compare_words("reinit");

      // Refresh instance: init, the digits, then two full refresh blocks 200 cycles apart.
      e2_addr.push_back(8'h0F); e2_data.push_back(8'h00);
      e2_addr.push_back(8'h0B); e2_data.push_back(8'h04);
      e2_addr.push_back(8'h09); e2_data.push_back(8'hFF);
      e2_addr.push_back(8'h0A); e2_data.push_back(8'h05);
      e2_addr.push_back(8'h0C); e2_data.push_back(8'h01);
      for (int i = 0; i < 8; i++) begin
         e2_addr.push_back(8'(i + 1));
         e2_data.push_back(8'h00);
      end
      for (int r = 0; r < 2; r++) begin
         e2_addr.push_back(8'h0C); e2_data.push_back(8'h01);
         e2_addr.push_back(8'h09); e2_data.push_back(8'hFF);
         e2_addr.push_back(8'h0A); e2_data.push_back(8'h05);
         for (int i = 0; i < 8; i++) begin
            e2_addr.push_back(8'(i + 1));
            e2_data.push_back(8'h00);
         end
      end
      for (int n = 0; n < 3000 && obs2_addr.size() < e2_addr.size(); n++) step();
      check_output("refresh_count", 32'(obs2_addr.size() >= e2_addr.size()), 32'd1);
      check_output("refresh_init_done", 32'(init_done_r), 32'd1);
      for (int i = 0; i < e2_addr.size(); i++) begin
         if (i < obs2_addr.size()) begin
            check_output($sformatf("refresh_addr%0d", i), 32'(obs2_addr[i]), 32'(e2_addr[i]));
            check_output($sformatf("refresh_data%0d", i), 32'(obs2_data[i]), 32'(e2_data[i]));
         end
      end
      if (obs2_time.size() >= 25)
         check_output("refresh_period", 32'(obs2_time[24] - obs2_time[13]), 32'd200);
      if (busy_r === 1'bx)
         check_output("refresh_busy_known", 32'd0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

endmodule
